// File: rtl/led_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_mode_sequencer_pkg
//  Brief    : Shared constants, mode/go-state enums and the mode decode helper
//             for the WS2812B mode sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package led_mode_sequencer_pkg;

  localparam int LED_BITS    = 24;
  localparam int MODE_STATIC = 0;

  typedef enum logic [1:0] {
    KIND_STATIC  = 2'd0,
    KIND_SOURCE  = 2'd1,
    KIND_AUTO    = 2'd2,
    KIND_INVALID = 2'd3
  } mode_kind_e;

  typedef enum logic [0:0] {
    GO_IDLE  = 1'b0,
    GO_ARMED = 1'b1
  } go_state_e;

  // 0 is static, 1..num_src pick a source, num_src+1 rotates, anything else is junk.
  function automatic mode_kind_e decode_mode(input int mode, input int num_src);
    mode_kind_e kind;
    if (mode == MODE_STATIC)       kind = KIND_STATIC;
    else if (mode <= num_src)      kind = KIND_SOURCE;
    else if (mode == num_src + 1)  kind = KIND_AUTO;
    else                           kind = KIND_INVALID;
    return kind;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_mode_sequencer_if
//  Brief    : Frame handshake between the mode sequencer (master) and the
//             WS2812B shift register (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface led_mode_sequencer_if
  import led_mode_sequencer_pkg::*;
#(
  parameter int NUM_LEDS = 4
);
  localparam int FW = LED_BITS * NUM_LEDS;

  logic          go;
  logic          frame_done;
  logic [FW-1:0] frame_data;

  modport master (output go, output frame_data, input frame_done);
  modport slave  (input go, input frame_data, output frame_done);

endinterface
`default_nettype wire

// File: rtl/led_mode_sequencer_rise_edge.sv
`default_nettype none
// ============================================================================
//  Module   : led_mode_sequencer_rise_edge
//  Brief    : One-cycle pulse on the rising edge of a level, compared against
//             a registered copy of the previous cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer_rise_edge (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic level_i,
  output logic      pulse_o
);

  logic level_q;

  // Remember last cycle's level so a held input yields a single pulse.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_mode_sequencer
//  Brief    : Picks the frame handed to the WS2812B shift register (static
//             colour, one source, or auto-rotation) and drives go. Mode and
//             frame changes take effect only at frame boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer
  import led_mode_sequencer_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int NUM_SRC     = 3,
  parameter int MODE_W      = 3,
  parameter int AUTO_FRAMES = 64
) (
  input  wire logic                              clk,
  input  wire logic                              reset,
  input  wire logic                              change_mode_i,
  input  wire logic [MODE_W-1:0]                 mode_sel_i,
  input  wire logic                              send_i,
  input  wire logic [3:0]                        green_i,
  input  wire logic [3:0]                        red_i,
  input  wire logic [3:0]                        blue_i,
  input  wire logic [NUM_SRC*LED_BITS*NUM_LEDS-1:0] src_data_i,
  led_mode_sequencer_if.master                   sr,
  output logic [MODE_W-1:0]                      active_mode_o,
  output logic                                   mode_pending_o
);

  localparam int FW = LED_BITS * NUM_LEDS;
  localparam int CW = $clog2(AUTO_FRAMES + 1);
  localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic              change_pulse, send_pulse;
  logic [MODE_W-1:0] active_mode_q, pending_mode_q, mode_d;
  logic              mode_pending_q;
  logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [RW-1:0]     rot_idx_q, rot_idx_d, src_idx;
  logic [FW-1:0]     frame_data_q, frame_data_d, static_frame, src_frame;
  logic [LED_BITS-1:0] static_led;
  go_state_e         go_state_q;
  logic              go_q;
  mode_kind_e        kind_active, kind_sel, kind_d;
  logic              boundary, apply, load_en;

  led_mode_sequencer_rise_edge u_change_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (change_mode_i),
    .pulse_o (change_pulse)
  );

  led_mode_sequencer_rise_edge u_send_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (send_i),
    .pulse_o (send_pulse)
  );

  // Boundary detection and the mode that will be in effect after this edge.
  always_comb begin
    kind_active = decode_mode(int'(active_mode_q), NUM_SRC);
    kind_sel    = decode_mode(int'(mode_sel_i), NUM_SRC);
    // An idle static display has no frame in flight, so every cycle is a boundary.
    boundary    = sr.frame_done | ((kind_active == KIND_STATIC) & ~go_q);
    apply       = boundary & mode_pending_q;
    mode_d      = apply ? pending_mode_q : active_mode_q;
    kind_d      = decode_mode(int'(mode_d), NUM_SRC);
    load_en     = sr.frame_done | ~go_q;
  end

  // Auto-rotate bookkeeping: a newly applied mode always restarts at source 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    rot_idx_d   = rot_idx_q;
    if (apply) begin
      frame_cnt_d = '0;
      rot_idx_d   = '0;
    end else if ((kind_active == KIND_AUTO) && sr.frame_done) begin
      if (frame_cnt_q == CW'(AUTO_FRAMES - 1)) begin
        frame_cnt_d = '0;
        rot_idx_d   = (rot_idx_q == RW'(NUM_SRC - 1)) ? '0 : rot_idx_q + RW'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  // Frame selection for the post-update mode.
  always_comb begin
    static_led   = {green_i, 4'h0, red_i, 4'h0, blue_i, 4'h0};
    static_frame = {NUM_LEDS{static_led}};
    src_idx      = (kind_d == KIND_AUTO) ? rot_idx_d : RW'(mode_d - MODE_W'(1));
    src_frame    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_idx == RW'(k)) src_frame = src_data_i[k*FW +: FW];
    end
    frame_data_d = (kind_d == KIND_STATIC) ? static_frame : src_frame;
  end

  // go FSM: sources always stream; static sends single shots on the send button.
  always_ff @(posedge clk) begin
    if (reset) begin
      go_state_q <= GO_IDLE;
      go_q       <= 1'b0;
    end else if (kind_d != KIND_STATIC) begin
      go_state_q <= GO_ARMED;
      go_q       <= 1'b1;
    end else begin
      case (go_state_q)
        GO_IDLE: begin
          if (send_pulse) begin
            go_state_q <= GO_ARMED;
            go_q       <= 1'b1;
          end
        end
        GO_ARMED: begin
          // A send press landing on frame_done re-arms for another frame.
          if (sr.frame_done && !send_pulse) begin
            go_state_q <= GO_IDLE;
            go_q       <= 1'b0;
          end
        end
        default: begin
          go_state_q <= GO_IDLE;
          go_q       <= 1'b0;
        end
      endcase
    end
  end

  // Mode, pending request, rotation counters and the frame register.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode_q  <= '0;
      pending_mode_q <= '0;
      mode_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
      rot_idx_q      <= '0;
      frame_data_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      rot_idx_q   <= rot_idx_d;
      if (apply) begin
        active_mode_q  <= pending_mode_q;
        mode_pending_q <= 1'b0;
      end
      // A request arriving on a boundary only queues; it waits for the next one.
      if (change_pulse && (kind_sel != KIND_INVALID)) begin
        pending_mode_q <= mode_sel_i;
        mode_pending_q <= 1'b1;
      end
      if (load_en) frame_data_q <= frame_data_d;
    end
  end

  assign sr.go          = go_q;
  assign sr.frame_data  = frame_data_q;
  assign active_mode_o  = active_mode_q;
  assign mode_pending_o = mode_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_mode_sequencer
//  Brief    : Directed self-checking bench for led_mode_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int NUM_LEDS    = 4;
  localparam int NUM_SRC     = 3;
  localparam int MODE_W      = 3;
  localparam int AUTO_FRAMES = 2;
  localparam int FW          = 24 * NUM_LEDS;

  localparam logic [FW-1:0] S0 = 96'h010203_040506_070809_0A0B0C;
  localparam logic [FW-1:0] S1 = 96'h111213_141516_171819_1A1B1C;
  localparam logic [FW-1:0] S2 = 96'h212223_242526_272829_2A2B2C;
  localparam logic [FW-1:0] ST_FFF = {4{24'hF0F0F0}};
  localparam logic [FW-1:0] ST_0FF = {4{24'h00F0F0}};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              change_mode = 1'b0;
  logic [MODE_W-1:0] mode_sel = '0;
  logic              send = 1'b0;
  logic [3:0]        green = 4'h0, red = 4'h0, blue = 4'h0;
  logic [NUM_SRC*FW-1:0] src_data;
  logic [MODE_W-1:0] active_mode;
  logic              mode_pending;

  int n_cmp  = 0;
  int n_fail = 0;

  led_mode_sequencer_if #(.NUM_LEDS(NUM_LEDS)) sr_if ();

  led_mode_sequencer #(
    .NUM_LEDS    (NUM_LEDS),
    .NUM_SRC     (NUM_SRC),
    .MODE_W      (MODE_W),
    .AUTO_FRAMES (AUTO_FRAMES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .change_mode_i  (change_mode),
    .mode_sel_i     (mode_sel),
    .send_i         (send),
    .green_i        (green),
    .red_i          (red),
    .blue_i         (blue),
    .src_data_i     (src_data),
    .sr             (sr_if),
    .active_mode_o  (active_mode),
    .mode_pending_o (mode_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    sr_if.frame_done = 1'b1;
    tick();
    sr_if.frame_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (sr_if.go !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %0b want 0", sr_if.go); end
    n_cmp++; if (sr_if.frame_data !== '0) begin n_fail++; $display("FAIL reset_frame: got %h want 0", sr_if.frame_data); end
    n_cmp++; if (active_mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", active_mode); end
    n_cmp++; if (mode_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b want 0", mode_pending); end
  endtask

  task automatic test_static();
    reset = 1'b0;
    green = 4'hF; red = 4'hF; blue = 4'hF;
    tick();
    n_cmp++; if (sr_if.frame_data !== ST_FFF) begin n_fail++; $display("FAIL static_idle_frame: got %h want %h", sr_if.frame_data, ST_FFF); end
    send = 1'b1;
    tick();
    send = 1'b0;
    n_cmp++; if (sr_if.go !== 1'b1) begin n_fail++; $display("FAIL static_go_set: got %0b want 1", sr_if.go); end
    green = 4'h0;
    tick();
    n_cmp++; if (sr_if.frame_data !== ST_FFF) begin n_fail++; $display("FAIL static_frame_hold: got %h want %h", sr_if.frame_data, ST_FFF); end
    pulse_done();
    n_cmp++; if (sr_if.go !== 1'b0) begin n_fail++; $display("FAIL static_go_clear: got %0b want 0", sr_if.go); end
    n_cmp++; if (sr_if.frame_data !== ST_0FF) begin n_fail++; $display("FAIL static_reload: got %h want %h", sr_if.frame_data, ST_0FF); end
    green = 4'hF;
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    send = 1'b1;
    sr_if.frame_done = 1'b1;
    tick();
    send = 1'b0;
    sr_if.frame_done = 1'b0;
    n_cmp++; if (sr_if.go !== 1'b1) begin n_fail++; $display("FAIL static_rearm: got %0b want 1", sr_if.go); end
    pulse_done();
    n_cmp++; if (sr_if.go !== 1'b0) begin n_fail++; $display("FAIL static_rearm_clear: got %0b want 0", sr_if.go); end
  endtask

  task automatic test_mode_request();
    send = 1'b1;
    tick();
    send = 1'b0;
    mode_sel = 3'd2;
    change_mode = 1'b1;
    tick();
    n_cmp++; if (mode_pending !== 1'b1) begin n_fail++; $display("FAIL req_pending_set: got %0b want 1", mode_pending); end
    for (int i = 0; i < 9; i++) tick();
    change_mode = 1'b0;
    n_cmp++; if (mode_pending !== 1'b1) begin n_fail++; $display("FAIL req_pending_held: got %0b want 1", mode_pending); end
    n_cmp++; if (active_mode !== 3'd0) begin n_fail++; $display("FAIL req_mode_wait: got %0d want 0", active_mode); end
    pulse_done();
    n_cmp++; if (active_mode !== 3'd2) begin n_fail++; $display("FAIL req_mode_applied: got %0d want 2", active_mode); end
    n_cmp++; if (mode_pending !== 1'b0) begin n_fail++; $display("FAIL req_pending_clear: got %0b want 0", mode_pending); end
    n_cmp++; if (sr_if.frame_data !== S1) begin n_fail++; $display("FAIL req_frame_src1: got %h want %h", sr_if.frame_data, S1); end
    tick();
    n_cmp++; if (sr_if.go !== 1'b1) begin n_fail++; $display("FAIL req_go_stream: got %0b want 1", sr_if.go); end
  endtask

  task automatic test_invalid_mode();
    mode_sel = 3'd7;
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
    n_cmp++; if (mode_pending !== 1'b0) begin n_fail++; $display("FAIL invalid_pending: got %0b want 0", mode_pending); end
    pulse_done();
    n_cmp++; if (active_mode !== 3'd2) begin n_fail++; $display("FAIL invalid_mode_kept: got %0d want 2", active_mode); end
  endtask

  task automatic test_auto_rotate();
    logic [FW-1:0] exp_q [0:5];
    exp_q[0] = S0; exp_q[1] = S1; exp_q[2] = S1;
    exp_q[3] = S2; exp_q[4] = S2; exp_q[5] = S0;
    mode_sel = 3'd4;
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
    pulse_done();
    n_cmp++; if (active_mode !== 3'd4) begin n_fail++; $display("FAIL auto_mode: got %0d want 4", active_mode); end
    n_cmp++; if (sr_if.frame_data !== S0) begin n_fail++; $display("FAIL auto_entry_frame: got %h want %h", sr_if.frame_data, S0); end
    for (int i = 0; i < 6; i++) begin
      pulse_done();
      n_cmp++;
      if (sr_if.frame_data !== exp_q[i]) begin
        n_fail++;
        $display("FAIL auto_rot_%0d: got %h want %h", i, sr_if.frame_data, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_coincident_request();
    mode_sel = 3'd3;
    change_mode = 1'b1;
    sr_if.frame_done = 1'b1;
    tick();
    change_mode = 1'b0;
    sr_if.frame_done = 1'b0;
    n_cmp++; if (mode_pending !== 1'b1) begin n_fail++; $display("FAIL coinc_pending: got %0b want 1", mode_pending); end
    n_cmp++; if (active_mode !== 3'd4) begin n_fail++; $display("FAIL coinc_mode_wait: got %0d want 4", active_mode); end
    n_cmp++; if (sr_if.frame_data !== S0) begin n_fail++; $display("FAIL coinc_frame: got %h want %h", sr_if.frame_data, S0); end
    tick();
    pulse_done();
    n_cmp++; if (active_mode !== 3'd3) begin n_fail++; $display("FAIL coinc_mode_applied: got %0d want 3", active_mode); end
    n_cmp++; if (sr_if.frame_data !== S2) begin n_fail++; $display("FAIL coinc_frame_src2: got %h want %h", sr_if.frame_data, S2); end
  endtask

  task automatic test_source_to_static();
    mode_sel = 3'd0;
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
    tick();
    pulse_done();
    n_cmp++; if (sr_if.go !== 1'b0) begin n_fail++; $display("FAIL to_static_go: got %0b want 0", sr_if.go); end
    n_cmp++; if (active_mode !== 3'd0) begin n_fail++; $display("FAIL to_static_mode: got %0d want 0", active_mode); end
    n_cmp++; if (sr_if.frame_data !== ST_FFF) begin n_fail++; $display("FAIL to_static_frame: got %h want %h", sr_if.frame_data, ST_FFF); end
  endtask

  task automatic test_reset_midframe();
    mode_sel = 3'd2;
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
    tick();
    n_cmp++; if (active_mode !== 3'd2) begin n_fail++; $display("FAIL idle_apply_mode: got %0d want 2", active_mode); end
    n_cmp++; if (sr_if.go !== 1'b1) begin n_fail++; $display("FAIL idle_apply_go: got %0b want 1", sr_if.go); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (sr_if.go !== 1'b0) begin n_fail++; $display("FAIL midreset_go: got %0b want 0", sr_if.go); end
    n_cmp++; if (sr_if.frame_data !== '0) begin n_fail++; $display("FAIL midreset_frame: got %h want 0", sr_if.frame_data); end
    n_cmp++; if (active_mode !== 3'd0) begin n_fail++; $display("FAIL midreset_mode: got %0d want 0", active_mode); end
    reset = 1'b0;
  endtask

  initial begin
    src_data = {S2, S1, S0};
    sr_if.frame_done = 1'b0;
    test_reset();
    test_static();
    test_mode_request();
    test_invalid_mode();
    test_auto_rotate();
    test_coincident_request();
    test_source_to_static();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
